decoder_sched: RTL and testbench

- Round-robin scheduler that shares one combinational decoder_proj datapath (7-bit input) between NUM_REQ requesters.
- Accepts one 7-bit code per transaction over a valid/ready handshake and drives the shared decoder input from a register.
- Waits a fixed settle time, then captures the decoder output and returns it with the requester ID over a valid/ready response port.
- Sits between the io_in-side sources and the shared decoder instance.

---
 rtl/decoder_pkg.sv | 17 +
 rtl/decoder_rr_arb.sv | 31 +++
 rtl/decoder_sched.sv | 95 +++++++++
 tb/tb_decoder_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder scheduler slice.
package decoder_pkg;

  localparam int CODE_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Pointer after grant g, wrapping at n; n need not be a power of two.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
  endfunction

endpackage

// File: rtl/decoder_rr_arb.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module decoder_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    gnt,
  output logic               any_req
);

  int              idx;
  logic [ID_W-1:0] idx_w;

  // Scan offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx   = (int'(rr_ptr) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (req[idx_w]) begin
        gnt     = idx_w;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_sched.sv
// Round-robin scheduler sharing one combinational decoder between requesters.
module decoder_sched
  import decoder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int OUT_W   = 8,
  parameter int SETTLE  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][CODE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [CODE_W-1:0]              dec_in,
  input  logic [OUT_W-1:0]               dec_out,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [OUT_W-1:0]               resp_data,
  output logic [ID_W-1:0]                resp_id,
  output logic                           busy
);

  // Counter only needs to hold SETTLE-1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr, gnt, gnt_q;
  logic             any_req;
  logic [CNT_W-1:0] cnt;

  decoder_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .any_req (any_req)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and accept strobe; ready is held low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: if (any_req && !reset) begin
        req_ready = NUM_REQ'(1) << gnt;
        state_d   = WAIT;
      end
      WAIT: if (cnt == '0) state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the granted code, count settle cycles, capture and hand off.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      dec_in     <= '0;
      gnt_q      <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          dec_in <= req_data[gnt];
          gnt_q  <= gnt;
          cnt    <= CNT_W'(SETTLE - 1);
        end
        WAIT: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          resp_data  <= dec_out;
          resp_id    <= gnt_q;
          resp_valid <= 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          rr_ptr     <= ID_W'(rr_next(32'(gnt_q), NUM_REQ));
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_sched.sv
// Scoreboard bench for decoder_sched with a stand-in decoder {1, ~code}.
module tb_decoder_sched;
  import decoder_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int OW = 8;

  // Codes per requester and their hand-decoded {1'b1, ~code} values.
  localparam logic [6:0] CODE [4] = '{7'h11, 7'h2A, 7'h5E, 7'h03};
  localparam logic [7:0] EXPD [4] = '{8'hEE, 8'hD5, 8'hA1, 8'hFC};

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]             req_valid, req_ready;
  logic [N-1:0][CODE_W-1:0] req_data;
  logic [CODE_W-1:0]        dec_in;
  logic [OW-1:0]            dec_out, resp_data;
  logic                     resp_valid, resp_ready, busy;
  logic [IW-1:0]            resp_id;

  logic [2:0]               c3_valid, c3_ready;
  logic [2:0][CODE_W-1:0]   c3_data;
  logic [CODE_W-1:0]        c3_dec_in;
  logic [OW-1:0]            c3_dec_out, c3_resp_data;
  logic                     c3_resp_valid, c3_resp_ready, c3_busy;
  logic [1:0]               c3_resp_id;

  assign dec_out    = {1'b1, ~dec_in};
  assign c3_dec_out = {1'b1, ~c3_dec_in};

  decoder_sched #(.NUM_REQ(4), .ID_W(2), .OUT_W(8), .SETTLE(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dec_in(dec_in), .dec_out(dec_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  decoder_sched #(.NUM_REQ(3), .ID_W(2), .OUT_W(8), .SETTLE(2)) dut3 (
    .clock(clock), .reset(reset), .req_valid(c3_valid), .req_data(c3_data),
    .req_ready(c3_ready), .dec_in(c3_dec_in), .dec_out(c3_dec_out),
    .resp_valid(c3_resp_valid), .resp_ready(c3_resp_ready), .resp_data(c3_resp_data),
    .resp_id(c3_resp_id), .busy(c3_busy)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [OW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [N-1:0] hs;
  int   pend [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = IW'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every accepted response must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0d data %0h, expected none", resp_id, resp_data);
      end else begin
        e = sb.pop_front();
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_data", 32'(resp_data), 32'(e.data));
      end
    end
  end

  function automatic int pend_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend[i];
    return s;
  endfunction

  // Sample the accept strobe mid-cycle; it takes effect at the next rising edge.
  task automatic neg();
    @(negedge clock);
    hs = req_ready;
  endtask

  // After the edge, retire accepted requests and drop valid once a requester is done.
  task automatic pos();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        if (pend[i] > 0) pend[i]--;
        req_valid[i] = (pend[i] != 0);
      end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((pend_total() != 0 || busy || sb.size() != 0) && k < 100) begin
      neg();
      pos();
      k++;
    end
    chk({name, "_drain"}, 32'(k < 100), 32'd1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    resp_ready = 1'b0;
    c3_valid = '0;
    c3_resp_ready = 1'b0;
    c3_data[0] = 7'h11; c3_data[1] = 7'h2A; c3_data[2] = 7'h03;
    for (int i = 0; i < N; i++) begin
      req_data[i] = CODE[i];
      pend[i] = 0;
    end
    hs = '0;
    req_valid = '1;

    // Reset state, with requests asserted to show ready is suppressed.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_dec_in", 32'(dec_in), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    req_valid = '0;
    @(posedge clock);
    #1 reset = 1'b0;

    // Reset in the middle of WAIT drops the transaction.
    req_data[1] = 7'h5E;
    pend[1] = 1;
    req_valid[1] = 1'b1;
    neg(); chk("t1_ready", 32'(req_ready), 32'b0010);
    pos();
    neg(); chk("t1_busy", 32'(busy), 32'd1); chk("t1_dec_in", 32'(dec_in), 32'h5E);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_dec_in", 32'(dec_in), 32'd0);
    chk("t1_async_resp_valid", 32'(resp_valid), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    resp_ready = 1'b1;
    repeat (6) begin
      neg(); chk("t1_no_resp", 32'(resp_valid), 32'd0);
      pos();
    end
    req_data[1] = CODE[1];

    // Single request from requester 2, latency check.
    pend[2] = 1;
    req_valid[2] = 1'b1;
    push(2, 8'hA1);
    neg(); chk("t2_ready", 32'(req_ready), 32'b0100);
    pos();
    neg(); chk("t2_dec_in", 32'(dec_in), 32'h5E); chk("t2_rv_t1", 32'(resp_valid), 32'd0);
    pos();
    neg(); chk("t2_rv_t2", 32'(resp_valid), 32'd0);
    pos();
    neg(); chk("t2_rv_t3", 32'(resp_valid), 32'd1); chk("t2_id", 32'(resp_id), 32'd2);
    pos();
    drain("t2");

    // Round robin from a fresh pointer with everyone valid.
    do_reset();
    pend[0] = 2; pend[1] = 2; pend[2] = 1; pend[3] = 1;
    req_valid = '1;
    push(0, EXPD[0]); push(1, EXPD[1]); push(2, EXPD[2]);
    push(3, EXPD[3]); push(0, EXPD[0]); push(1, EXPD[1]);
    drain("rr");

    // Backpressure: pointer is now 2; hold the response for several cycles.
    resp_ready = 1'b0;
    pend[2] = 1; pend[3] = 1;
    req_valid[2] = 1'b1; req_valid[3] = 1'b1;
    push(2, EXPD[2]); push(3, EXPD[3]);
    k = 0;
    neg();
    while (!resp_valid && k < 20) begin
      pos(); neg(); k++;
    end
    chk("bp_resp_seen", 32'(resp_valid), 32'd1);
    repeat (5) begin
      chk("bp_data", 32'(resp_data), 32'hA1);
      chk("bp_id", 32'(resp_id), 32'd2);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      pos(); neg();
    end
    pos();
    resp_ready = 1'b1;
    neg();
    pos();
    neg(); chk("bp_next_grant", 32'(req_ready), 32'b1000);
    pos();
    drain("bp");

    // Late request: 3 raises valid while 0 is in flight.
    pend[0] = 1;
    req_valid[0] = 1'b1;
    push(0, EXPD[0]);
    neg(); chk("late_r0", 32'(req_ready), 32'b0001);
    pos();
    pend[3] = 1;
    req_valid[3] = 1'b1;
    push(3, EXPD[3]);
    neg(); chk("late_wait_a", 32'(req_ready), 32'd0);
    pos();
    neg(); chk("late_wait_b", 32'(req_ready), 32'd0);
    pos();
    neg(); chk("late_resp", 32'(req_ready), 32'd0);
    pos();
    neg(); chk("late_r3", 32'(req_ready), 32'b1000);
    pos();
    drain("late");

    // NUM_REQ=3: after grant 2 the pointer wraps to 0.
    c3_resp_ready = 1'b1;
    c3_valid = 3'b100;
    @(negedge clock);
    chk("w_ready2", 32'(c3_ready), 32'b100);
    @(posedge clock);
    #1 c3_valid = 3'b011;
    k = 0;
    do begin @(negedge clock); k++; end while (!c3_resp_valid && k < 20);
    chk("w_id2", 32'(c3_resp_id), 32'd2);
    chk("w_data2", 32'(c3_resp_data), 32'hFC);
    k = 0;
    do begin @(negedge clock); k++; end while (c3_ready == '0 && k < 20);
    chk("w_grant0", 32'(c3_ready), 32'b001);
    @(posedge clock);
    #1 c3_valid = 3'b010;
    k = 0;
    do begin @(negedge clock); k++; end while (!c3_resp_valid && k < 20);
    chk("w_id0", 32'(c3_resp_id), 32'd0);
    chk("w_data0", 32'(c3_resp_data), 32'hEE);
    @(posedge clock);
    #1 c3_valid = '0;

    repeat (3) @(posedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
